fp_add_unpack: RTL and testbench
================================

Name: fp_add_unpack

Overview:
- First pipeline stage of the FP32 adder/subtractor.
- Per cycle, accepts two IEEE-754 single-precision operands and an add/sub opcode, and classifies each operand into ZERO/INF/SUBNORMAL/NORMAL/NAN.
- Resolves special cases to a final result.
- Otherwise sorts operands by magnitude and emits aligned-stage inputs (big/small mantissas, exponent difference, effective operation) to the downstream alignment shifter.
- One registered stage with valid/ready handshake.

Parameters:
- QNAN, 32'h7FC0_0000, canonical quiet-NaN pattern returned for any NaN result.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  operand set valid
- in_ready  out  1  stage can accept operand set
- op_a  in  32  operand A, IEEE-754 single
- op_b  in  32  operand B, IEEE-754 single
- op_sub  in  1  1 = A - B, 0 = A + B
- out_valid  out  1  registered result valid
- out_ready  in  1  downstream accepts
- out_special  out  1  1 = out_special_res is final; datapath fields don't-care
- out_special_res  out  32  final IEEE result for special cases
- out_type_a  out  3  class code of A
- out_type_b  out  3  class code of B
- out_sign  out  1  sign of larger-magnitude operand (B sign after op_sub inversion)
- out_eff_sub  out  1  effective subtraction
- out_exp_big  out  8  effective exponent of larger operand
- out_exp_diff  out  8  exp_big - exp_small, unsigned
- out_mant_big  out  24  {hidden, fraction} of larger operand
- out_mant_small  out  24  {hidden, fraction} of smaller operand

Behaviour:
- Reset: out_valid=0; all registered outputs 0. Reset asserted mid-operation discards the held result; no output handshake completes.
- in_ready = !out_valid | out_ready (combinational, no bubble).
- Transfer in = in_valid & in_ready. Output registers load on transfer in; latency 1 cycle.
- out_valid:
  - set on transfer in;
  - cleared when out_ready & !transfer-in;
  - stays 1 on simultaneous consume and accept.
- Stall (out_valid & !out_ready): all outputs held bit-stable; in_ready=0.
- Field split: sign=[31], exp=[30:23], frac=[22:0].
- Class codes: ZERO=000, INF=001, SUBNORMAL=010, NORMAL=011, NAN=100.
  - exp==0: frac==0 → ZERO, else SUBNORMAL.
  - exp==255: frac==0 → INF, else NAN.
  - otherwise NORMAL.
- Effective B sign sb' = sign_b ^ op_sub. eff_sub = sign_a ^ sb'.
- Effective exponent: 1 for ZERO/SUBNORMAL, else exp. Hidden bit: 1 only for NORMAL.
- Magnitude order: compare op_a[30:0] vs op_b[30:0] unsigned. A is big when A >= B (tie → A big).
- Special priority, first match wins (out_special=1):
  1. Either NaN → QNAN.
  2. Both INF and eff_sub → QNAN.
  3. A INF → {sign_a, 8'hFF, 23'b0}.
  4. B INF → {sb', 8'hFF, 23'b0}.
  5. Both ZERO → {sign_a & sb', 31'b0} (round-to-nearest rule).
  6. A ZERO → {sb', op_b[30:0]}.
  7. B ZERO → op_a.
- No special: out_special=0, out_special_res=0, datapath fields valid.
- out_exp_diff is up to 254, no wrap (big effective exp >= small).
- out_type_a/b are always driven, special or not.

Decomposition:
- Shared package fp_pkg:
  - class-code constants ZERO/INF/SUBNORMAL/NORMAL/NAN (3 bits);
  - field-width constants EXP_W=8, FRAC_W=23, BIAS=127;
  - QNAN constant.
- Classification uses the existing type_detect block, instantiated twice (A and B).
- No new sub-module. Special resolution and sort are combinational logic before the single output register.

Test Plan:
- 1.0 + 2.0: op_a=3F800000, op_b=40000000, op_sub=0 → 1 cycle later out_valid=1, special=0, exp_big=0x80, exp_diff=1, mant_big=800000, mant_small=800000, eff_sub=0, sign=0, types 011/011.
- Inf - Inf: 7F800000, 7F800000, op_sub=1 → special=1, res=7FC00000. Then NaN+1.0 (7F800001, 3F800000) → res=7FC00000, type_a=100.
- Zeros: -0 + -0 → res=80000000. +0 - +0 (op_sub=1) → res=00000000. 0 + 00000001 → res=00000001, type_b=010.
- Subnormal vs normal: 00400000 - 3F800000 → big=B, sign=1, eff_sub=1, exp_big=0x7F, exp_diff=0x7E, mant_small=400000.
- Backpressure: out_ready=0 for 3 cycles with in_valid held → in_ready=0, outputs stable. Release → back-to-back transfers at one per cycle, no loss or duplication across 8 random vectors.
- Reset pulse while out_valid=1 → out_valid=0 immediately (async), all outputs 0; first post-reset transfer correct.

Source files
------------

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_pkg
// Description : Shared FP32 constants for the adder/subtractor pipeline:
//               IEEE-754 single field widths, exponent bias, operand class
//               codes and the canonical quiet-NaN pattern.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    // Operand class codes
    localparam logic [2:0] ZERO      = 3'b000;
    localparam logic [2:0] INF       = 3'b001;
    localparam logic [2:0] SUBNORMAL = 3'b010;
    localparam logic [2:0] NORMAL    = 3'b011;
    localparam logic [2:0] NAN       = 3'b100;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

endpackage : fp_pkg
`default_nettype wire

// File: rtl/type_detect.sv
`default_nettype none
// ============================================================================
// Module      : type_detect
// Description : Classifies one IEEE-754 single-precision value into
//               ZERO / INF / SUBNORMAL / NORMAL / NAN. Purely combinational.
// Ports       : val       in  32  IEEE-754 single operand
//               type_code out  3   class code (fp_pkg encoding)
// Revision    : 1.0 - initial release
// ============================================================================
module type_detect
    import fp_pkg::*;
(
    input  logic [31:0] val,
    output logic [2:0]  type_code
);

    logic [EXP_W-1:0] w_exp;
    logic             w_frac_nz;

    assign w_exp     = val[30:23];
    assign w_frac_nz = |val[22:0];

    always_comb begin
        type_code = NORMAL;
        if (w_exp == '0) begin
            type_code = w_frac_nz ? SUBNORMAL : ZERO;
        end else if (w_exp == '1) begin
            type_code = w_frac_nz ? NAN : INF;
        end
    end

endmodule : type_detect
`default_nettype wire

// File: rtl/fp_add_unpack.sv
`default_nettype none
// ============================================================================
// Module      : fp_add_unpack
// Description : First stage of the FP32 adder/subtractor. Classifies both
//               operands, resolves special cases to a final result, and
//               otherwise sorts the operands by magnitude to feed the
//               alignment shifter. One registered stage, valid/ready.
// Ports       : clk, rst (async, active-high)
//               in_valid/in_ready, op_a, op_b, op_sub   - operand set
//               out_valid/out_ready                     - result handshake
//               out_special, out_special_res            - final special result
//               out_type_a, out_type_b                  - operand classes
//               out_sign, out_eff_sub, out_exp_big, out_exp_diff,
//               out_mant_big, out_mant_small            - aligned-stage inputs
// Revision    : 1.0 - initial release
// ============================================================================
module fp_add_unpack #(
    parameter logic [31:0] QNAN = fp_pkg::QNAN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        op_sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_special,
    output logic [31:0] out_special_res,
    output logic [2:0]  out_type_a,
    output logic [2:0]  out_type_b,
    output logic        out_sign,
    output logic        out_eff_sub,
    output logic [7:0]  out_exp_big,
    output logic [7:0]  out_exp_diff,
    output logic [23:0] out_mant_big,
    output logic [23:0] out_mant_small
);

    import fp_pkg::*;

    logic [2:0]  w_type_a, w_type_b;
    logic        w_sign_a, w_sign_b;
    logic        w_eff_sub;
    logic [7:0]  w_exp_a, w_exp_b;
    logic [23:0] w_mant_a, w_mant_b;
    logic        w_a_big;
    logic        w_special;
    logic [31:0] w_special_res;
    logic [7:0]  w_exp_big, w_exp_small;
    logic        w_xfer_in;

    type_detect u_type_a (.val(op_a), .type_code(w_type_a));
    type_detect u_type_b (.val(op_b), .type_code(w_type_b));

    // B's sign folded with the opcode so the rest of the stage only sees an add
    assign w_sign_a  = op_a[31];
    assign w_sign_b  = op_b[31] ^ op_sub;
    assign w_eff_sub = w_sign_a ^ w_sign_b;

    // Subnormals share the minimum normal exponent; only normals carry a hidden 1
    assign w_exp_a  = (w_type_a == ZERO || w_type_a == SUBNORMAL) ? 8'd1 : op_a[30:23];
    assign w_exp_b  = (w_type_b == ZERO || w_type_b == SUBNORMAL) ? 8'd1 : op_b[30:23];
    assign w_mant_a = {(w_type_a == NORMAL), op_a[22:0]};
    assign w_mant_b = {(w_type_b == NORMAL), op_b[22:0]};

    // Exponent/fraction concatenation orders magnitude directly; tie keeps A big
    assign w_a_big     = (op_a[30:0] >= op_b[30:0]);
    assign w_exp_big   = w_a_big ? w_exp_a : w_exp_b;
    assign w_exp_small = w_a_big ? w_exp_b : w_exp_a;

    always_comb begin
        w_special     = 1'b1;
        w_special_res = '0;
        if (w_type_a == NAN || w_type_b == NAN) begin
            w_special_res = QNAN;
        end else if (w_type_a == INF && w_type_b == INF && w_eff_sub) begin
            w_special_res = QNAN;
        end else if (w_type_a == INF) begin
            w_special_res = {w_sign_a, 8'hFF, 23'b0};
        end else if (w_type_b == INF) begin
            w_special_res = {w_sign_b, 8'hFF, 23'b0};
        end else if (w_type_a == ZERO && w_type_b == ZERO) begin
            // Round-to-nearest: only (-0) + (-0) yields -0
            w_special_res = {w_sign_a & w_sign_b, 31'b0};
        end else if (w_type_a == ZERO) begin
            w_special_res = {w_sign_b, op_b[30:0]};
        end else if (w_type_b == ZERO) begin
            w_special_res = op_a;
        end else begin
            w_special = 1'b0;
        end
    end

    assign in_ready  = !out_valid || out_ready;
    assign w_xfer_in = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid       <= 1'b0;
            out_special     <= 1'b0;
            out_special_res <= '0;
            out_type_a      <= '0;
            out_type_b      <= '0;
            out_sign        <= 1'b0;
            out_eff_sub     <= 1'b0;
            out_exp_big     <= '0;
            out_exp_diff    <= '0;
            out_mant_big    <= '0;
            out_mant_small  <= '0;
        end else begin
            if (w_xfer_in) begin
                out_valid       <= 1'b1;
                out_special     <= w_special;
                out_special_res <= w_special_res;
                out_type_a      <= w_type_a;
                out_type_b      <= w_type_b;
                out_sign        <= w_a_big ? w_sign_a : w_sign_b;
                out_eff_sub     <= w_eff_sub;
                out_exp_big     <= w_exp_big;
                out_exp_diff    <= w_exp_big - w_exp_small;
                out_mant_big    <= w_a_big ? w_mant_a : w_mant_b;
                out_mant_small  <= w_a_big ? w_mant_b : w_mant_a;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule : fp_add_unpack
`default_nettype wire

// File: tb/tb_fp_add_unpack.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_add_unpack
// Description : Scoreboard bench for fp_add_unpack. Directed operand sets
//               with hand-computed expectations are queued on acceptance; a
//               monitor pops and compares on every output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_add_unpack;

    localparam logic [2:0] TZ = 3'b000, TI = 3'b001, TS = 3'b010,
                           TN = 3'b011, TQ = 3'b100;
    localparam logic [31:0] QN = 32'h7FC0_0000;

    typedef struct packed {
        logic        special;
        logic [31:0] res;
        logic [2:0]  ta;
        logic [2:0]  tb;
        logic        sign;
        logic        eff;
        logic [7:0]  eb;
        logic [7:0]  ed;
        logic [23:0] mb;
        logic [23:0] ms;
    } exp_t;

    logic        clk, rst, in_valid, in_ready, op_sub, out_valid, out_ready;
    logic [31:0] op_a, op_b, out_special_res;
    logic        out_special, out_sign, out_eff_sub;
    logic [2:0]  out_type_a, out_type_b;
    logic [7:0]  out_exp_big, out_exp_diff;
    logic [23:0] out_mant_big, out_mant_small;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    int   qid[$];

    fp_add_unpack dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_special(out_special), .out_special_res(out_special_res),
        .out_type_a(out_type_a), .out_type_b(out_type_b),
        .out_sign(out_sign), .out_eff_sub(out_eff_sub),
        .out_exp_big(out_exp_big), .out_exp_diff(out_exp_diff),
        .out_mant_big(out_mant_big), .out_mant_small(out_mant_small)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t sp(input logic [31:0] res, input logic [2:0] ta, input logic [2:0] tb);
        exp_t e;
        e = '0;
        e.special = 1'b1; e.res = res; e.ta = ta; e.tb = tb;
        return e;
    endfunction

    function automatic exp_t dp(input logic [2:0] ta, input logic [2:0] tb, input logic sign,
                                input logic eff, input logic [7:0] eb, input logic [7:0] ed,
                                input logic [23:0] mb, input logic [23:0] ms);
        exp_t e;
        e = '0;
        e.ta = ta; e.tb = tb; e.sign = sign; e.eff = eff;
        e.eb = eb; e.ed = ed; e.mb = mb; e.ms = ms;
        return e;
    endfunction

    task automatic check_item(input exp_t e, input int id, input string what);
        logic ok;
        ok = (out_special === e.special) && (out_special_res === e.res) &&
             (out_type_a === e.ta) && (out_type_b === e.tb);
        if (!e.special)
            ok = ok && (out_sign === e.sign) && (out_eff_sub === e.eff) &&
                 (out_exp_big === e.eb) && (out_exp_diff === e.ed) &&
                 (out_mant_big === e.mb) && (out_mant_small === e.ms);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s vec%0d: got sp=%b res=%h ta=%b tb=%b s=%b eff=%b eb=%h ed=%h mb=%h ms=%h; want sp=%b res=%h ta=%b tb=%b s=%b eff=%b eb=%h ed=%h mb=%h ms=%h",
                     what, id, out_special, out_special_res, out_type_a, out_type_b, out_sign,
                     out_eff_sub, out_exp_big, out_exp_diff, out_mant_big, out_mant_small,
                     e.special, e.res, e.ta, e.tb, e.sign, e.eff, e.eb, e.ed, e.mb, e.ms);
        end
    endtask

    // Monitor: consume on every output handshake
    always @(negedge clk) begin
        #2;
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got res=%h with empty scoreboard, want no output", out_special_res);
            end else begin
                check_item(q.pop_front(), qid.pop_front(), "result");
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input exp_t e, input int id);
        int n;
        @(negedge clk);
        op_a = a; op_b = b; op_sub = s; in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (in_ready) begin
            q.push_back(e);
            qid.push_back(id);
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout vec%0d: got in_ready=0 for 20 cycles, want 1", id);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending, want 0", q.size());
            q.delete();
            qid.delete();
        end
    endtask

    exp_t e_one_two, e_stall_a;

    initial begin
        rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; op_sub = 1'b0; out_ready = 1'b1;
        e_one_two = dp(TN, TN, 1'b0, 1'b0, 8'h80, 8'h01, 24'h800000, 24'h800000);
        e_stall_a = dp(TN, TN, 1'b0, 1'b0, 8'h80, 8'h00, 24'hC00000, 24'h800000);

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
            {out_special, out_special_res, out_type_a, out_type_b, out_sign, out_eff_sub,
             out_exp_big, out_exp_diff, out_mant_big, out_mant_small} !== '0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b in_ready=%b res=%h mb=%h, want 0 1 0 0",
                     out_valid, in_ready, out_special_res, out_mant_big);
        end
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors, back-to-back
        send(32'h3F800000, 32'h40000000, 1'b0, e_one_two, 1);
        send(32'h7F800000, 32'h7F800000, 1'b1, sp(QN, TI, TI), 2);
        send(32'h7F800001, 32'h3F800000, 1'b0, sp(QN, TQ, TN), 3);
        send(32'h80000000, 32'h80000000, 1'b0, sp(32'h80000000, TZ, TZ), 4);
        send(32'h00000000, 32'h00000000, 1'b1, sp(32'h00000000, TZ, TZ), 5);
        send(32'h00000000, 32'h00000001, 1'b0, sp(32'h00000001, TZ, TS), 6);
        send(32'h00400000, 32'h3F800000, 1'b1,
             dp(TS, TN, 1'b1, 1'b1, 8'h7F, 8'h7E, 24'h800000, 24'h400000), 7);
        send(32'h7F800000, 32'h3F800000, 1'b0, sp(32'h7F800000, TI, TN), 8);
        send(32'h3F800000, 32'h7F800000, 1'b1, sp(32'hFF800000, TN, TI), 9);
        send(32'h40400000, 32'h00000000, 1'b0, sp(32'h40400000, TN, TZ), 10);
        send(32'h3F800000, 32'h3F800000, 1'b1,
             dp(TN, TN, 1'b0, 1'b1, 8'h7F, 8'h00, 24'h800000, 24'h800000), 11);
        send(32'hFF800000, 32'h7F800000, 1'b0, sp(QN, TI, TI), 12);
        send(32'h7F7FFFFF, 32'h00000001, 1'b0,
             dp(TN, TS, 1'b0, 1'b0, 8'hFE, 8'hFD, 24'hFFFFFF, 24'h000001), 13);
        idle();
        drain();

        // Backpressure: hold one result, keep the next offered for 3 cycles
        @(negedge clk);
        out_ready = 1'b0;
        send(32'h40000000, 32'h40400000, 1'b0, e_stall_a, 20);
        @(negedge clk);
        op_a = 32'h41200000; op_b = 32'h3F800000; op_sub = 1'b1; in_valid = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_handshake cyc%0d: got in_ready=%b out_valid=%b, want 0 1",
                         i, in_ready, out_valid);
            end
            check_item(e_stall_a, 20, "stall_hold");
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        if (in_ready) begin
            q.push_back(dp(TN, TN, 1'b0, 1'b1, 8'h82, 8'h03, 24'hA00000, 24'h800000));
            qid.push_back(21);
        end else begin
            checks++;
            errors++;
            $display("FAIL release_ready: got in_ready=0, want 1");
        end
        send(32'hC0000000, 32'h3F800000, 1'b0,
             dp(TN, TN, 1'b1, 1'b1, 8'h80, 8'h01, 24'h800000, 24'h800000), 22);
        send(32'h3F000000, 32'h3F800000, 1'b0,
             dp(TN, TN, 1'b0, 1'b0, 8'h7F, 8'h01, 24'h800000, 24'h800000), 23);
        send(32'hBF800000, 32'hBF800000, 1'b1,
             dp(TN, TN, 1'b1, 1'b1, 8'h7F, 8'h00, 24'h800000, 24'h800000), 24);
        send(32'h42C80000, 32'h3DCCCCCD, 1'b0,
             dp(TN, TN, 1'b0, 1'b0, 8'h85, 8'h0A, 24'hC80000, 24'hCCCCCD), 25);
        send(32'h00800000, 32'h00000001, 1'b0,
             dp(TN, TS, 1'b0, 1'b0, 8'h01, 8'h00, 24'h800000, 24'h000001), 26);
        send(32'h3F800000, 32'hBF800000, 1'b0,
             dp(TN, TN, 1'b0, 1'b1, 8'h7F, 8'h00, 24'h800000, 24'h800000), 27);
        idle();
        drain();

        // Asynchronous reset while a result is held
        @(negedge clk);
        out_ready = 1'b0;
        send(32'h3F800000, 32'h40000000, 1'b0, e_one_two, 30);
        idle();
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_valid: got out_valid=%b, want 1", out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 ||
            {out_special, out_special_res, out_type_a, out_type_b, out_sign, out_eff_sub,
             out_exp_big, out_exp_diff, out_mant_big, out_mant_small} !== '0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b res=%h eb=%h mb=%h, want all 0",
                     out_valid, out_special_res, out_exp_big, out_mant_big);
        end
        q.delete();
        qid.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        send(32'h3F800000, 32'h40000000, 1'b0, e_one_two, 31);
        idle();
        drain();

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL final_idle: got pending=%0d out_valid=%b, want 0 0", q.size(), out_valid);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fp_add_unpack
`default_nettype wire
